taxi_eth_phy_rx_watchdog_mlane: RTL and testbench
=================================================

Name: taxi_eth_phy_rx_watchdog_mlane

Overview:
Multi-lane SERDES receive watchdog for multi-lane PCS receive paths (e.g. 4x10G/25G lanes behind 40G/100G framing).
- All lanes share one 125 us window timer. Each lane is monitored independently for sync-header health, block/sequence errors and high BER.
- Outputs per lane: a reset-request pulse and a link-status bit; plus an aggregate all-lanes-up status.
- Generalises the single-lane watchdog:
  - configurable lane count and thresholds;
  - high-BER as a window-fail cause;
  - post-reset hold-off so a lane cannot re-request before its SERDES recovers.

Parameters:
LANES, 4, number of monitored lanes (1..16)
HDR_W, 2, sync header width per lane; any other value is a $fatal elaboration error
COUNT_125US, 125000/6.4, real; clk cycles per 125 us window (converted with $rtoi)
ERR_LIMIT, 16, consecutive bad windows before a reset request (2..256)
STATUS_LIMIT, 15, consecutive good windows before rx_status sets (1..255)
HOLDOFF_WIN, 4, windows suppressed after a reset request (1..255)
BLK_ERR_W, 10, width of the per-lane saturating block-error counter

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
serdes_rx_hdr  input  LANES*HDR_W  per-lane sync headers, lane i at [i*HDR_W +: HDR_W]
serdes_rx_hdr_valid  input  LANES  per-lane header valid
rx_bad_block  input  LANES  per-lane bad block strobe
rx_sequence_error  input  LANES  per-lane sequence error strobe
rx_block_lock  input  LANES  per-lane block lock
rx_high_ber  input  LANES  per-lane high BER level
serdes_rx_reset_req  output  LANES  one-cycle reset request pulse per lane
rx_status  output  LANES  per-lane link good
rx_status_all  output  1  AND of all rx_status bits, registered
stat_reset_req_count  output  LANES*16  per-lane reset request counts (see Optional Feature)

Behaviour:
- Reset (asynchronous assert; every register cleared):
  - all outputs 0;
  - timer loaded with COUNT_125US_INT;
  - all per-lane counters 0;
  - lane FSMs in HUNT.
- Timer:
  - COUNT_W = $clog2(COUNT_125US_INT+1).
  - Decrements each cycle. At 0 it asserts window_end for that cycle and reloads COUNT_125US_INT, giving a window of COUNT_125US_INT+1 cycles.
- Per-lane accumulation (only while rx_block_lock[i]=1):
  - saw_ctrl set on valid header == 2'b01;
  - blk_err increments on (bad_block | sequence_error), saturating at all-ones;
  - saw_hber set on rx_high_ber.
- Window verdict: a window is bad if !saw_ctrl, or blk_err saturated, or saw_hber. At window_end, saw_ctrl, blk_err and saw_hber clear.
- Lane FSM states: HUNT, GOOD, HOLDOFF.
  - HUNT, window_end:
    - bad window: err_cnt++, stat_cnt=0. If err_cnt was ERR_LIMIT-1, then serdes_rx_reset_req[i]=1 in the next cycle, err_cnt=0, hold_cnt=HOLDOFF_WIN-1, go to HOLDOFF.
    - good window: err_cnt=0, stat_cnt++ (saturating). If stat_cnt was STATUS_LIMIT-1, set rx_status[i]=1 and go to GOOD.
  - GOOD, window_end:
    - bad window: err_cnt++, stat_cnt=0, rx_status[i]=0, go to HUNT. The reset-request rule applies identically.
    - good window: err_cnt=0.
  - HOLDOFF:
    - accumulators are held cleared; verdicts are ignored; rx_status=0;
    - at window_end, hold_cnt decrements; at 0 the lane goes to HUNT with counters 0.
  - Lock loss in any state except HOLDOFF: next cycle rx_status[i]=0, stat_cnt=0, state HUNT. err_cnt keeps counting, because the window verdict is bad.
- Simultaneous events:
  - lock loss on a window_end that would set status: status stays 0;
  - reset request and status set cannot coincide, because the verdict is exclusive.
- Latency:
  - reset_req and status change 1 cycle after window_end;
  - rx_status_all follows 1 cycle after rx_status.
- serdes_rx_reset_req is exactly one cycle wide.
- Lanes are fully independent; no cross-lane interaction except rx_status_all.

Optional Feature:
TAXI_RX_WATCHDOG_STATS_EN
- Defined: each lane has a 16-bit saturating counter that increments on every serdes_rx_reset_req pulse, cleared by rst, driven on stat_reset_req_count.
- Undefined: the counters are not instantiated and stat_reset_req_count is tied to 0. The port list is unchanged.

Decomposition:
- Package taxi_eth_phy_rx_watchdog_pkg: lane FSM state enum (HUNT/GOOD/HOLDOFF), SYNC_DATA=2'b10 and SYNC_CTRL=2'b01 constants.
- Sub-module taxi_eth_phy_rx_watchdog_lane: one lane's accumulators, counters and FSM. Inputs are window_end plus that lane's signals. The top holds the shared timer, a generate loop over the lanes, rx_status_all and the stats option.

Test Plan:
Common bench configuration: LANES=4, COUNT_125US=15 (16-cycle window), ERR_LIMIT=4, STATUS_LIMIT=3, HOLDOFF_WIN=2, BLK_ERR_W=3.
1. All lanes locked with a ctrl header every window -> rx_status=4'b1111 one cycle after the 3rd window_end; rx_status_all one cycle later; no reset_req.
2. Lane 2 never sees a ctrl header -> serdes_rx_reset_req[2] single-cycle pulse one cycle after the 4th window_end. Then no evaluation for 2 windows, then a second pulse 4 windows after that. Other lanes are unaffected.
3. Lane 0 in GOOD; 7 bad_block strobes in one window -> rx_status[0] drops one cycle after that window_end, rx_status_all=0. 6 strobes -> status is kept.
4. Lane 1 in GOOD; rx_block_lock[1] drops mid-window -> rx_status[1]=0 the next cycle. Re-lock -> status returns only after 3 good windows.
5. rx_high_ber[3] pulsed once per window -> lane 3 never reaches GOOD; reset_req[3] fires every 4 + 2 windows. With TAXI_RX_WATCHDOG_STATS_EN, the lane 3 count increments per pulse.
6. Assert rst mid-window while lane 2 is in HOLDOFF -> all outputs 0 immediately (asynchronous). After release, the timer restarts a full 16-cycle window.

Source files
------------

// File: rtl/taxi_eth_phy_rx_watchdog_pkg.sv
// Shared types and sync-header constants for the multi-lane PCS receive watchdog.
package taxi_eth_phy_rx_watchdog_pkg;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      GOOD    = 2'd1,
      HOLDOFF = 2'd2
   } lane_state_t;

   localparam logic [1:0] SYNC_DATA = 2'b10;
   localparam logic [1:0] SYNC_CTRL = 2'b01;

endpackage

// File: rtl/taxi_eth_phy_rx_watchdog_lane.sv
// One lane of the receive watchdog: per-window health accumulators, the
// bad/good window counters and the HUNT/GOOD/HOLDOFF state machine.
module taxi_eth_phy_rx_watchdog_lane
   import taxi_eth_phy_rx_watchdog_pkg::*;
#(
   parameter int HDR_W        = 2,
   parameter int ERR_LIMIT    = 16,
   parameter int STATUS_LIMIT = 15,
   parameter int HOLDOFF_WIN  = 4,
   parameter int BLK_ERR_W    = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             window_end_i,
   input  logic [HDR_W-1:0] hdr_i,
   input  logic             hdr_valid_i,
   input  logic             bad_block_i,
   input  logic             seq_err_i,
   input  logic             lock_i,
   input  logic             high_ber_i,
   output logic             reset_req_o,
   output logic             status_o
);

   localparam int         ERR_W     = $clog2(ERR_LIMIT);
   localparam [ERR_W-1:0] ERR_TOP   = ERR_W'(ERR_LIMIT - 1);
   localparam [7:0]       STAT_SET  = 8'(STATUS_LIMIT - 1);
   localparam [7:0]       HOLD_INIT = 8'(HOLDOFF_WIN - 1);

   lane_state_t          state_q;
   logic                 saw_ctrl_q, saw_hber_q;
   logic [BLK_ERR_W-1:0] blk_err_q;
   logic [ERR_W-1:0]     err_cnt_q;
   logic [7:0]           stat_cnt_q, hold_cnt_q;
   logic                 reset_req_q, status_q;

   logic                 saw_ctrl_d, saw_hber_d;
   logic [BLK_ERR_W-1:0] blk_err_d;
   logic                 bad_win, enter_hold;

   // Accumulators include this cycle's sample so the window_end cycle is not
   // lost; while unlocked they stay cleared, so a window ending unlocked is bad.
   always_comb begin
      saw_ctrl_d = lock_i && (saw_ctrl_q || (hdr_valid_i && hdr_i == HDR_W'(SYNC_CTRL)));
      saw_hber_d = lock_i && (saw_hber_q || high_ber_i);
      blk_err_d  = blk_err_q;
      if (!lock_i)
         blk_err_d = '0;
      else if ((bad_block_i || seq_err_i) && !(&blk_err_q))
         blk_err_d = blk_err_q + BLK_ERR_W'(1);
   end

   assign bad_win    = !saw_ctrl_d || (&blk_err_d) || saw_hber_d;
   assign enter_hold = window_end_i && bad_win && (err_cnt_q == ERR_TOP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= HUNT;
         saw_ctrl_q  <= 1'b0;
         saw_hber_q  <= 1'b0;
         blk_err_q   <= '0;
         err_cnt_q   <= '0;
         stat_cnt_q  <= '0;
         hold_cnt_q  <= '0;
         reset_req_q <= 1'b0;
         status_q    <= 1'b0;
      end else begin
         reset_req_q <= 1'b0;
         if (state_q == HOLDOFF) begin
            saw_ctrl_q <= 1'b0;
            saw_hber_q <= 1'b0;
            blk_err_q  <= '0;
            status_q   <= 1'b0;
            if (window_end_i) begin
               if (hold_cnt_q == '0) begin
                  state_q    <= HUNT;
                  err_cnt_q  <= '0;
                  stat_cnt_q <= '0;
               end else begin
                  hold_cnt_q <= hold_cnt_q - 8'd1;
               end
            end
         end else begin
            saw_ctrl_q <= window_end_i ? 1'b0 : saw_ctrl_d;
            saw_hber_q <= window_end_i ? 1'b0 : saw_hber_d;
            blk_err_q  <= window_end_i ? '0 : blk_err_d;
            if (window_end_i) begin
               if (bad_win) begin
                  stat_cnt_q <= '0;
                  status_q   <= 1'b0;
                  if (enter_hold) begin
                     reset_req_q <= 1'b1;
                     err_cnt_q   <= '0;
                     hold_cnt_q  <= HOLD_INIT;
                     state_q     <= HOLDOFF;
                  end else begin
                     err_cnt_q <= err_cnt_q + ERR_W'(1);
                     state_q   <= HUNT;
                  end
               end else begin
                  err_cnt_q <= '0;
                  if (state_q == HUNT) begin
                     if (stat_cnt_q != 8'hFF)
                        stat_cnt_q <= stat_cnt_q + 8'd1;
                     if (stat_cnt_q == STAT_SET) begin
                        status_q <= 1'b1;
                        state_q  <= GOOD;
                     end
                  end
               end
            end
            // Lock loss drops status at once; a pending reset request still wins.
            if (!lock_i && !enter_hold) begin
               status_q   <= 1'b0;
               stat_cnt_q <= '0;
               state_q    <= HUNT;
            end
         end
      end
   end

   assign reset_req_o = reset_req_q;
   assign status_o    = status_q;

endmodule

// File: rtl/taxi_eth_phy_rx_watchdog_mlane.sv
// Multi-lane receive watchdog: shared 125 us window timer, one lane monitor
// per lane, aggregate status. Per-lane reset-request counters: TAXI_RX_WATCHDOG_STATS_EN.
module taxi_eth_phy_rx_watchdog_mlane
   import taxi_eth_phy_rx_watchdog_pkg::*;
#(
   parameter int  LANES        = 4,
   parameter int  HDR_W        = 2,
   parameter real COUNT_125US  = 125000/6.4,
   parameter int  ERR_LIMIT    = 16,
   parameter int  STATUS_LIMIT = 15,
   parameter int  HOLDOFF_WIN  = 4,
   parameter int  BLK_ERR_W    = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [LANES*HDR_W-1:0] serdes_rx_hdr,
   input  logic [LANES-1:0]       serdes_rx_hdr_valid,
   input  logic [LANES-1:0]       rx_bad_block,
   input  logic [LANES-1:0]       rx_sequence_error,
   input  logic [LANES-1:0]       rx_block_lock,
   input  logic [LANES-1:0]       rx_high_ber,
   output logic [LANES-1:0]       serdes_rx_reset_req,
   output logic [LANES-1:0]       rx_status,
   output logic                   rx_status_all,
   output logic [LANES*16-1:0]    stat_reset_req_count
);

   localparam int COUNT_125US_INT = $rtoi(COUNT_125US);
   localparam int COUNT_W         = $clog2(COUNT_125US_INT + 1);

   if (HDR_W != 2) begin : g_hdr_chk
      $fatal(1, "HDR_W must be 2");
   end

   logic [COUNT_W-1:0] timer_q;
   logic               window_end;
   logic               status_all_q;

   assign window_end = (timer_q == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer_q      <= COUNT_W'(COUNT_125US_INT);
         status_all_q <= 1'b0;
      end else begin
         timer_q      <= window_end ? COUNT_W'(COUNT_125US_INT) : timer_q - COUNT_W'(1);
         status_all_q <= &rx_status;
      end
   end

   assign rx_status_all = status_all_q;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      taxi_eth_phy_rx_watchdog_lane #(
         .HDR_W        (HDR_W),
         .ERR_LIMIT    (ERR_LIMIT),
         .STATUS_LIMIT (STATUS_LIMIT),
         .HOLDOFF_WIN  (HOLDOFF_WIN),
         .BLK_ERR_W    (BLK_ERR_W)
      ) u_lane (
         .clk          (clk),
         .rst          (rst),
         .window_end_i (window_end),
         .hdr_i        (serdes_rx_hdr[i*HDR_W +: HDR_W]),
         .hdr_valid_i  (serdes_rx_hdr_valid[i]),
         .bad_block_i  (rx_bad_block[i]),
         .seq_err_i    (rx_sequence_error[i]),
         .lock_i       (rx_block_lock[i]),
         .high_ber_i   (rx_high_ber[i]),
         .reset_req_o  (serdes_rx_reset_req[i]),
         .status_o     (rx_status[i])
      );
   end

`ifdef TAXI_RX_WATCHDOG_STATS_EN
   logic [LANES-1:0][15:0] stat_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_q <= '0;
      end else begin
         for (int i = 0; i < LANES; i++)
            if (serdes_rx_reset_req[i] && stat_q[i] != 16'hFFFF)
               stat_q[i] <= stat_q[i] + 16'd1;
      end
   end

   assign stat_reset_req_count = stat_q;
`else
   assign stat_reset_req_count = '0;
`endif

endmodule

// File: tb/tb_taxi_eth_phy_rx_watchdog_mlane.sv
// Scoreboard bench: stimulus queues hand-computed output events (cycle after
// reset release plus output values); a negedge monitor pops one per output change.
module tb_taxi_eth_phy_rx_watchdog_mlane;

   localparam int LANES = 4;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [LANES*2-1:0] hdr;
   logic [LANES-1:0]   hdr_valid = '1;
   logic [LANES-1:0]   bad_block = '0;
   logic [LANES-1:0]   seq_err   = '0;
   logic [LANES-1:0]   lock      = '1;
   logic [LANES-1:0]   hber      = '0;
   logic [LANES-1:0]   ctrl_en   = '1;
   logic [LANES-1:0]   req, st;
   logic               st_all;
   logic [LANES*16-1:0] stat_cnt;

   always #5 clk = ~clk;

   always_comb
      for (int i = 0; i < LANES; i++)
         hdr[i*2 +: 2] = ctrl_en[i] ? 2'b01 : 2'b10;

   taxi_eth_phy_rx_watchdog_mlane #(
      .LANES(LANES), .HDR_W(2), .COUNT_125US(15.0), .ERR_LIMIT(4),
      .STATUS_LIMIT(3), .HOLDOFF_WIN(2), .BLK_ERR_W(3)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .serdes_rx_hdr        (hdr),
      .serdes_rx_hdr_valid  (hdr_valid),
      .rx_bad_block         (bad_block),
      .rx_sequence_error    (seq_err),
      .rx_block_lock        (lock),
      .rx_high_ber          (hber),
      .serdes_rx_reset_req  (req),
      .rx_status            (st),
      .rx_status_all        (st_all),
      .stat_reset_req_count (stat_cnt)
   );

   typedef struct {
      int         cyc;
      logic [3:0] req;
      logic [3:0] st;
      logic       all;
   } ev_t;

   ev_t exp_q[$];
   int  cyc;
   int  n_chk  = 0;
   int  n_pass = 0;
   logic [3:0] prev_st;
   logic       prev_all;

   // Cycle 0 is the release cycle; window w ends on cycle 16w-1.
   always @(posedge clk or posedge rst)
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;

   always @(negedge clk) begin
      ev_t e;
      if (rst) begin
         prev_st  = '0;
         prev_all = 1'b0;
      end else if (req != '0 || st != prev_st || st_all != prev_all) begin
         n_chk++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: got cyc=%0d req=%b st=%b all=%b, want none",
                     cyc, req, st, st_all);
         end else begin
            e = exp_q.pop_front();
            if (e.cyc == cyc && e.req == req && e.st == st && e.all == st_all)
               n_pass++;
            else
               $display("FAIL event: got cyc=%0d req=%b st=%b all=%b, want cyc=%0d req=%b st=%b all=%b",
                        cyc, req, st, st_all, e.cyc, e.req, e.st, e.all);
         end
         prev_st  = st;
         prev_all = st_all;
      end
   end

   function automatic void push(int c, logic [3:0] r, logic [3:0] s, logic a);
      ev_t e;
      e.cyc = c; e.req = r; e.st = s; e.all = a;
      exp_q.push_back(e);
   endfunction

   task automatic to_cyc(int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      exp_q.delete();
      ctrl_en   = '1;
      lock      = '1;
      bad_block = '0;
      seq_err   = '0;
      hber      = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic drain(string name);
      n_chk++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL %s_missing: got %0d events still pending, want 0", name, exp_q.size());
   endtask

   task automatic chk(string name, logic [63:0] got, logic [63:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", name, got, want);
   endtask

   initial begin
      // 1: all lanes good
      do_reset();
      chk("reset_outputs", {req, st, st_all}, 64'h0);
      push(48, 4'b0000, 4'b1111, 1'b0);
      push(49, 4'b0000, 4'b1111, 1'b1);
      to_cyc(100);
      drain("all_good");

      // 2: lane 2 never sees a ctrl header
      do_reset();
      ctrl_en = 4'b1011;
      push(48,  4'b0000, 4'b1011, 1'b0);
      push(64,  4'b0100, 4'b1011, 1'b0);
      push(160, 4'b0100, 4'b1011, 1'b0);
      to_cyc(170);
      drain("no_ctrl");

      // 3: block-error saturation on lane 0 (6 strobes keep, 7 drop)
      do_reset();
      push(48,  4'b0000, 4'b1111, 1'b0);
      push(49,  4'b0000, 4'b1111, 1'b1);
      push(80,  4'b0000, 4'b1110, 1'b1);
      push(81,  4'b0000, 4'b1110, 1'b0);
      push(128, 4'b0000, 4'b1111, 1'b0);
      push(129, 4'b0000, 4'b1111, 1'b1);
      to_cyc(50); bad_block[0] = 1'b1;
      to_cyc(56); bad_block[0] = 1'b0;
      to_cyc(66); bad_block[0] = 1'b1;
      to_cyc(73); bad_block[0] = 1'b0;
      to_cyc(135);
      drain("blk_err");

      // 4: lane 1 lock loss mid-window, re-lock in window 6
      do_reset();
      push(48,  4'b0000, 4'b1111, 1'b0);
      push(49,  4'b0000, 4'b1111, 1'b1);
      push(71,  4'b0000, 4'b1101, 1'b1);
      push(72,  4'b0000, 4'b1101, 1'b0);
      push(128, 4'b0000, 4'b1111, 1'b0);
      push(129, 4'b0000, 4'b1111, 1'b1);
      to_cyc(70); lock[1] = 1'b0;
      to_cyc(84); lock[1] = 1'b1;
      to_cyc(135);
      drain("lock_loss");

      // 5: high BER on lane 3 once per window
      do_reset();
      push(48,  4'b0000, 4'b0111, 1'b0);
      push(64,  4'b1000, 4'b0111, 1'b0);
      push(160, 4'b1000, 4'b0111, 1'b0);
      push(256, 4'b1000, 4'b0111, 1'b0);
      for (int w = 0; w < 16; w++) begin
         to_cyc(16*w + 5); hber[3] = 1'b1;
         to_cyc(16*w + 6); hber[3] = 1'b0;
      end
      to_cyc(260);
      drain("high_ber");
`ifdef TAXI_RX_WATCHDOG_STATS_EN
      chk("stat_count", 64'(stat_cnt), {16'd3, 16'd0, 16'd0, 16'd0});
`else
      chk("stat_count", 64'(stat_cnt), 64'h0);
`endif

      // 6: async reset while lane 2 is in HOLDOFF, then full window restart
      do_reset();
      ctrl_en = 4'b1011;
      push(48, 4'b0000, 4'b1011, 1'b0);
      push(64, 4'b0100, 4'b1011, 1'b0);
      to_cyc(70);
      drain("pre_reset");
      #3 rst = 1'b1;
      #1 chk("async_reset", {req, st, st_all, 16'(stat_cnt)}, 64'h0);
      push(48, 4'b0000, 4'b1011, 1'b0);
      push(64, 4'b0100, 4'b1011, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      to_cyc(70);
      drain("post_reset");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
